// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ready handshake and
// presents {PC+4, instruction, valid} to the IF/ID register, with stall, redirect and squash.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] addressout,
    output logic [31:0] instructionout,
    output logic        valid_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_addr_q;
    logic        squash_q;
    logic [31:0] hold_buf_q;
    logic [31:0] addressout_q;
    logic [31:0] instr_q;
    logic        valid_q;

    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] req_addr_inc;

    // Branch resolves in an older instruction than a jump, so it wins.
    assign redirect        = branch_taken | jump;
    assign redirect_target = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
    assign req_addr_inc    = req_addr_q + 32'd4;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            req_addr_q   <= 32'h0000_0000;
            squash_q     <= 1'b0;
            hold_buf_q   <= 32'h0000_0000;
            addressout_q <= 32'h0000_0000;
            instr_q      <= NOP_INSTR;
            valid_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    if (redirect) begin
                        pc_q       <= redirect_target;
                        req_addr_q <= redirect_target;
                        instr_q    <= NOP_INSTR;
                        valid_q    <= 1'b0;
                    end else begin
                        req_addr_q <= pc_q;
                    end
                end

                FETCH: begin
                    if (redirect) begin
                        pc_q    <= redirect_target;
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                        // The address must stay put until the outstanding request completes.
                        if (imem_ready) begin
                            squash_q   <= 1'b0;
                            req_addr_q <= redirect_target;
                        end else begin
                            squash_q <= 1'b1;
                        end
                    end else if (!imem_ready || squash_q) begin
                        if (imem_ready) begin
                            squash_q   <= 1'b0;
                            req_addr_q <= pc_q;
                        end
                        if (!stall) begin
                            instr_q <= NOP_INSTR;
                            valid_q <= 1'b0;
                        end
                    end else if (!stall) begin
                        instr_q      <= imem_rdata;
                        addressout_q <= req_addr_inc;
                        valid_q      <= 1'b1;
                        pc_q         <= req_addr_inc;
                        req_addr_q   <= req_addr_inc;
                    end else begin
                        hold_buf_q <= imem_rdata;
                        state_q    <= HOLD;
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        pc_q       <= redirect_target;
                        req_addr_q <= redirect_target;
                        instr_q    <= NOP_INSTR;
                        valid_q    <= 1'b0;
                        state_q    <= FETCH;
                    end else if (!stall) begin
                        instr_q      <= hold_buf_q;
                        addressout_q <= req_addr_inc;
                        valid_q      <= 1'b1;
                        pc_q         <= req_addr_inc;
                        req_addr_q   <= req_addr_inc;
                        state_q      <= FETCH;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_req       = (state_q == FETCH);
    assign imem_addr      = req_addr_q;
    assign addressout     = addressout_q;
    assign instructionout = instr_q;
    assign valid_out      = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed test of if_fetch_stage: reset, streaming, stall-on-return, squash, redirect
// priority, PC wrap, target alignment and reset during an outstanding request.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] addressout;
    logic [31:0] instructionout;
    logic        valid_out;

    int n_assert = 0;
    int n_fail   = 0;

    if_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .addressout     (addressout),
        .instructionout (instructionout),
        .valid_out      (valid_out)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] ad, input logic [31:0] ins,
                           input logic vld);
        chk({tag, ".addr"},  addressout,     ad);
        chk({tag, ".instr"}, instructionout, ins);
        chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, vld});
    endtask

    initial begin
        // Reset held low for two cycles with random inputs.
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            stall         = 1'($urandom);
            branch_taken  = 1'($urandom);
            branch_target = $urandom;
            jump          = 1'($urandom);
            jump_target   = $urandom;
            imem_ready    = 1'($urandom);
            imem_rdata    = $urandom;
            step();
            chk("rst.req", {31'd0, imem_req}, 32'd0);
            chk_out("rst", 32'h0, 32'h0, 1'b0);
        end

        // Release with zero-wait memory.
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0;
        imem_ready = 1'b1; imem_rdata = 32'hBAD0_0000;
        step();
        chk("rel.req",  {31'd0, imem_req}, 32'd1);
        chk("rel.addr", imem_addr, 32'h0);
        imem_rdata = 32'h1111_0000;
        step();
        chk_out("s0", 32'h4, 32'h1111_0000, 1'b1);
        chk("s0.iaddr", imem_addr, 32'h4);
        imem_rdata = 32'h1111_0004;
        step();
        chk_out("s1", 32'h8, 32'h1111_0004, 1'b1);
        chk("s1.iaddr", imem_addr, 32'h8);

        // Data returns while stalled: buffered, outputs frozen for three cycles.
        stall = 1'b1; imem_rdata = 32'h8C22_0004;
        step();
        chk_out("hold0", 32'h8, 32'h1111_0004, 1'b1);
        chk("hold0.req", {31'd0, imem_req}, 32'd0);
        imem_ready = 1'b0; imem_rdata = 32'hBAD0_0001;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_out("holdn", 32'h8, 32'h1111_0004, 1'b1);
            chk("holdn.req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        step();
        chk_out("unhold", 32'hC, 32'h8C22_0004, 1'b1);
        chk("unhold.iaddr", imem_addr, 32'hC);
        chk("unhold.req", {31'd0, imem_req}, 32'd1);

        // Redirect while the request at 0x10 is waiting.
        imem_ready = 1'b1; imem_rdata = 32'h1111_000C;
        step();
        chk_out("f0c", 32'h10, 32'h1111_000C, 1'b1);
        chk("f0c.iaddr", imem_addr, 32'h10);
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
        step();
        chk_out("br", 32'h10, 32'h0, 1'b0);
        chk("br.iaddr", imem_addr, 32'h10);
        branch_taken = 1'b0;
        step();
        chk("wait.iaddr", imem_addr, 32'h10);
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        chk_out("squash", 32'h10, 32'h0, 1'b0);
        chk("squash.iaddr", imem_addr, 32'h200);
        imem_rdata = 32'h2222_0200;
        step();
        chk_out("f200", 32'h204, 32'h2222_0200, 1'b1);

        // Branch and jump together under stall: branch wins, outputs bubbled.
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        jump = 1'b1; jump_target = 32'h80; imem_rdata = 32'hBAD0_0204;
        step();
        chk_out("bj", 32'h204, 32'h0, 1'b0);
        chk("bj.iaddr", imem_addr, 32'h40);
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; imem_rdata = 32'h4444_0040;
        step();
        chk_out("f40", 32'h44, 32'h4444_0040, 1'b1);

        // PC wrap.
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; imem_rdata = 32'hBAD0_0044;
        step();
        chk("wrap.iaddr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap.valid", {31'd0, valid_out}, 32'd0);
        branch_taken = 1'b0; imem_rdata = 32'hFFFF_0000;
        step();
        chk_out("wrap", 32'h0, 32'hFFFF_0000, 1'b1);
        chk("wrap2.iaddr", imem_addr, 32'h0);

        // Unaligned jump target is forced to a word boundary.
        jump = 1'b1; jump_target = 32'h103; imem_rdata = 32'hBAD0_0008;
        step();
        chk("unal.iaddr", imem_addr, 32'h100);
        jump = 1'b0; imem_ready = 1'b0;
        step();
        chk("wait100.req", {31'd0, imem_req}, 32'd1);

        // Reset while a request is outstanding; late ready in IDLE is ignored.
        reset = 1'b0;
        step();
        chk("rstm.req", {31'd0, imem_req}, 32'd0);
        chk("rstm.iaddr", imem_addr, 32'h0);
        chk_out("rstm", 32'h0, 32'h0, 1'b0);
        reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hBAD0_0100;
        step();
        chk_out("late", 32'h0, 32'h0, 1'b0);
        chk("late.req", {31'd0, imem_req}, 32'd1);
        imem_ready = 1'b0;
        step();
        chk("late2.valid", {31'd0, valid_out}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction fetch stage directly upstream of the IF/ID pipeline register. It owns the PC, issues word requests to instruction memory over a req/ready handshake, and presents {PC+4, instruction, valid} for IF/ID to latch. It honours hazard-unit stalls and branch/jump redirects, and squashes in-flight fetches made stale by a redirect.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INSTR, 32'h00000000, instruction word driven on bubbles (MIPS sll $0,$0,0)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset; reset==0 at a posedge resets the block
stall  input  1  hazard unit: hold outputs, do not advance PC
branch_taken  input  1  branch resolved taken this cycle
branch_target  input  32  branch destination
jump  input  1  jump this cycle
jump_target  input  32  jump destination
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch word address, stable while imem_req=1 and imem_ready=0
imem_ready  input  1  imem_rdata valid for imem_addr this cycle; completes request
imem_rdata  input  32  fetched instruction
addressout  output  32  PC+4 of presented instruction (to IF/ID addressin)
instructionout  output  32  presented instruction (to IF/ID instructionin)
valid_out  output  1  instructionout is a real instruction, not a bubble

Behaviour:
- Reset (reset==0 at posedge, overrides all inputs and any in-flight request): pc=RESET_PC, req_addr=0, state=IDLE, squash=0, hold_buf=0, imem_req=0, imem_addr=0, addressout=0, instructionout=NOP_INSTR, valid_out=0. A request outstanding at reset is abandoned; imem_ready arriving afterwards is ignored while in IDLE.
- States: IDLE, FETCH, HOLD.
- IDLE: imem_req=0. Next cycle goes to FETCH with req_addr=pc.
- FETCH: imem_req=1, imem_addr=req_addr (registered, never changes mid-request).
  - imem_ready=0: outputs get bubble (instructionout=NOP_INSTR, valid_out=0) unless stall=1, in which case outputs hold.
  - imem_ready=1, squash=1: data dropped, squash<=0, req_addr<=pc, stay FETCH; outputs as for no data.
  - imem_ready=1, squash=0, stall=0: instructionout<=imem_rdata, addressout<=req_addr+4, valid_out<=1, pc<=req_addr+4, req_addr<=req_addr+4; stay FETCH. Back-to-back fetches: one instruction per cycle with single-cycle memory.
  - imem_ready=1, squash=0, stall=1: hold_buf<=imem_rdata, go HOLD; outputs hold.
- HOLD: imem_req=0; outputs hold while stall=1. First cycle with stall=0: present hold_buf (addressout=req_addr+4, valid_out=1), pc and req_addr<=req_addr+4, go FETCH.
- Redirect (branch_taken or jump), evaluated every non-reset cycle, overrides stall:
  - Priority: branch_taken over jump (branch is older). target[1:0] forced to 00.
  - pc<=target; outputs flushed to bubble (NOP_INSTR, valid_out=0; addressout holds).
  - FETCH with imem_ready=0: squash<=1 (request completes, then dropped); req_addr unchanged until then.
  - FETCH with imem_ready=1: data dropped, req_addr<=target, no squash.
  - HOLD: hold_buf discarded, req_addr<=target, go FETCH.
  - IDLE: req_addr<=target.
  - A second redirect while squash=1 updates pc only; the last target wins.
- Arithmetic: 32-bit unsigned, PC+4 wraps modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
- Latency: imem_ready cycle -> outputs valid at next posedge (1 cycle).

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> imem_req=0, addressout=0, instructionout=0, valid_out=0; release -> first imem_addr=RESET_PC, then 4, 8, with valid_out=1 each cycle and zero-wait memory.
- Stall on data return: imem_ready=1 with rdata=32'h8C220004 and stall=1 for 3 cycles -> outputs frozen, imem_req=0; on stall=0, instructionout=32'h8C220004, addressout=req_addr+4 next cycle.
- Redirect mid-wait: request at 32'h10 with ready delayed 3 cycles; branch_taken with target 32'h200 in cycle 1 -> the data for 32'h10 is never presented; next imem_addr=32'h200.
- Simultaneous branch_taken (32'h40) and jump (32'h80) while stall=1 -> bubble on outputs, next fetch address 32'h40.
- Wrap: branch to 32'hFFFFFFFC -> addressout=0, next imem_addr=0; unaligned target 32'h103 -> fetch 32'h100.
- Reset mid-request: imem_req=1 waiting, assert reset=0 -> all outputs reset; a late imem_ready=1 pulse in IDLE leaves valid_out=0.
